uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, single-clock UART transmitter with an integrated transmit FIFO and internal baud generator. It runs entirely on the 100 MHz system clock, so no slow UART clock and no clock-domain crossing are needed. It generalises the fixed 8N1 transmitter to configurable data width, parity and stop bits, and accepts words through a valid/ready handshake. It drives RsTx to the RS232 peripheral.

## Interface
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200); legal range ≥ 2.
- DATA_BITS, 8: data bits per frame, 5–9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO words; power of two, ≥ 2.

- clk  in  1  system clock, 100 MHz.
- reset  in  1  one clock; reset is synchronous and active-high.
- tx_valid  in  1  producer has a word on tx_data.
- tx_data  in  DATA_BITS  word to send.
- tx_ready  out  1  FIFO can accept a word; high iff fifo_count < FIFO_DEPTH.
- tx_busy  out  1  a frame is on the line; high iff FSM ≠ IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently queued.
- RsTx  out  1  serial line; idle high.

## Operation
- Push: tx_valid && tx_ready at a rising edge writes tx_data to the FIFO tail. A push while full is not accepted, and tx_ready is low in that case. tx_ready depends only on the registered count.
- Pop: the FSM pops the FIFO head when it is in IDLE, or on the final cycle of the last stop bit, with fifo_count > 0.
- A simultaneous push and pop leaves fifo_count unchanged.
- A push to an empty FIFO does not fall through; the pop occurs at the earliest on the next cycle.
- FSM states and transitions:
  - IDLE, RsTx = 1: go to START on a pop.
  - START, RsTx = 0.
  - DATA: bits LSB first; the bit index counts 0..DATA_BITS−1.
  - PARITY, skipped if PARITY = 0: even parity sends XOR of the data bits; odd parity sends its inverse.
  - STOP, RsTx = 1: the stop-bit index counts 0..STOP_BITS−1.
  - End of STOP: go to START if a word is available (back-to-back, zero idle gap), else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT−1 and clears on every state or bit change. Every bit occupies exactly CLKS_PER_BIT cycles.
- Frame length is (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- The popped word is latched into a shift register at pop. Later pushes do not affect the frame in flight.
- RsTx is driven from a register, so it is glitch-free.

## Timing
- Reset values: RsTx = 1, tx_ready = 1, tx_busy = 0, fifo_count = 0. FSM = IDLE; FIFO pointers and counters are 0.
- Reset mid-frame: at the next edge the line returns high, the FIFO is flushed and any frame in flight is abandoned.
- Latency: a word accepted at edge T into an empty FIFO with the FSM in IDLE gives fifo_count = 1 after T. The pop happens at T+1, and RsTx and tx_busy change after edge T+1. That is 2 cycles from the push edge to the start bit.
- fifo_count and tx_ready update one cycle after the push or pop edge.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH; a full FIFO is count = FIFO_DEPTH, not pointer equality.
- tx_busy stays high continuously across back-to-back frames.

## Test plan
1. Reset: assert reset for 3 cycles mid-stream -> RsTx = 1, tx_ready = 1, tx_busy = 0, fifo_count = 0 one cycle after reset is sampled.
2. Single word, CLKS_PER_BIT = 4, 8N1, push 0xA5 -> RsTx low 2 cycles after the push. Then the sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles, a 40-cycle frame. Then idle high and tx_busy = 0.
3. Parity, DATA_BITS = 8, push 0x07 -> with PARITY = 1 the bit after data is 1; with PARITY = 2 it is 0. Frame is 44 cycles at CLKS_PER_BIT = 4.
4. Backpressure, FIFO_DEPTH = 4, tx_valid held high for 6 consecutive words -> 5 words accepted (the first is popped at once) and fifo_count reaches 4. tx_ready = 0 until the first frame's stop bit ends; word 6 is accepted on the cycle after that pop.
5. Back-to-back, STOP_BITS = 2, 3 queued words -> stop high for exactly 2 × CLKS_PER_BIT cycles, then the next start bit with no extra idle. tx_busy never drops between frames.
6. DATA_BITS = 5, push 0x1F with upper tx_data bits ignored -> 5 data bits of 1 and a frame of 7 × CLKS_PER_BIT cycles. A push during that frame does not alter it.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
// Module   : uart_tx_fifo_if
// Summary  : Valid/ready word handshake between a producer and the UART
//            transmit FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
) ();

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   // Producer side
   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready
   );

   // Transmitter side
   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready
   );

endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Summary  : Single-clock UART transmitter with integrated transmit FIFO and
//            internal baud counter. Configurable data width, parity and stop
//            bits; words arrive over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   uart_tx_fifo_if.slave                 tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          RsTx
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W  = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0]  c_depth     = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] c_last_baud = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  c_last_bit  = IDX_W'(DATA_BITS - 1);
   localparam logic              c_last_stop = 1'(STOP_BITS - 1);
   localparam bit                c_has_par   = (PARITY != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]    r_wr_ptr;
   logic [ADDR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]     r_count;

   logic                 w_ready;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_has_word;
   logic [DATA_BITS-1:0] w_head;
   logic                 w_head_par;

   // Transmit FSM registers and their next values
   state_t               r_state;
   state_t               w_state_n;
   logic [BAUD_W-1:0]    r_baud;
   logic [BAUD_W-1:0]    w_baud_n;
   logic [IDX_W-1:0]     r_bit;
   logic [IDX_W-1:0]     w_bit_n;
   logic [IDX_W-1:0]     w_bit_inc;
   logic                 r_stop;
   logic                 w_stop_n;
   logic [DATA_BITS-1:0] r_word;
   logic [DATA_BITS-1:0] w_word_n;
   logic                 r_par;
   logic                 w_par_n;
   logic                 r_line;
   logic                 w_line_n;

   logic                 w_baud_end;
   logic                 w_last_bit;
   logic                 w_last_stop;

   // Ready comes only from the registered count, so no combinational path
   // runs from tx_valid back to tx_ready.
   assign w_ready     = (r_count < c_depth);
   assign w_push      = tx.tx_valid && w_ready;
   assign w_has_word  = (r_count != '0);
   assign w_head      = r_mem[r_rd_ptr];

   assign w_baud_end  = (r_baud == c_last_baud);
   assign w_last_bit  = (r_bit == c_last_bit);
   assign w_last_stop = (r_stop == c_last_stop);
   assign w_bit_inc   = r_bit + IDX_W'(1);

   assign tx.tx_ready = w_ready;
   assign fifo_count  = r_count;
   assign tx_busy     = (r_state != S_IDLE);
   assign RsTx        = r_line;

   // Parity of the word being popped is captured with it, so the shift of
   // the data bits never has to be undone later in the frame.
   generate
      if (PARITY == 2) begin : g_par_odd
         assign w_head_par = ~(^w_head);
      end else begin : g_par_even
         assign w_head_par = ^w_head;
      end
   endgenerate

   // FIFO storage write; contents need no reset because the count gates reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tx.tx_data;
      end
   end

   // FIFO pointers wrap naturally; fullness is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM state, counters, latched word and the registered serial line.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_stop  <= 1'b0;
         r_word  <= '0;
         r_par   <= 1'b0;
         r_line  <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_baud  <= w_baud_n;
         r_bit   <= w_bit_n;
         r_stop  <= w_stop_n;
         r_word  <= w_word_n;
         r_par   <= w_par_n;
         r_line  <= w_line_n;
      end
   end

   // Next state, next line level and pop; the line is computed one cycle
   // ahead so it is driven straight from a flop.
   always_comb begin
      w_state_n = r_state;
      w_baud_n  = r_baud + BAUD_W'(1);
      w_bit_n   = r_bit;
      w_stop_n  = r_stop;
      w_word_n  = r_word;
      w_par_n   = r_par;
      w_line_n  = r_line;
      w_pop     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_baud_n = '0;
            w_line_n = 1'b1;
            if (w_has_word) begin
               w_pop     = 1'b1;
               w_state_n = S_START;
               w_word_n  = w_head;
               w_par_n   = w_head_par;
               w_line_n  = 1'b0;
            end
         end

         S_START: begin
            if (w_baud_end) begin
               w_state_n = S_DATA;
               w_baud_n  = '0;
               w_bit_n   = '0;
               w_line_n  = r_word[0];
            end
         end

         S_DATA: begin
            if (w_baud_end) begin
               w_baud_n = '0;
               if (w_last_bit) begin
                  if (c_has_par) begin
                     w_state_n = S_PARITY;
                     w_line_n  = r_par;
                  end else begin
                     w_state_n = S_STOP;
                     w_stop_n  = 1'b0;
                     w_line_n  = 1'b1;
                  end
               end else begin
                  w_bit_n  = w_bit_inc;
                  w_line_n = r_word[w_bit_inc];
               end
            end
         end

         S_PARITY: begin
            if (w_baud_end) begin
               w_state_n = S_STOP;
               w_baud_n  = '0;
               w_stop_n  = 1'b0;
               w_line_n  = 1'b1;
            end
         end

         S_STOP: begin
            if (w_baud_end) begin
               w_baud_n = '0;
               if (w_last_stop) begin
                  // Back-to-back frames start with no idle gap.
                  if (w_has_word) begin
                     w_pop     = 1'b1;
                     w_state_n = S_START;
                     w_word_n  = w_head;
                     w_par_n   = w_head_par;
                     w_line_n  = 1'b0;
                  end else begin
                     w_state_n = S_IDLE;
                     w_line_n  = 1'b1;
                  end
               end else begin
                  w_stop_n = r_stop + 1'b1;
                  w_line_n = 1'b1;
               end
            end
         end

         default: begin
            w_state_n = S_IDLE;
            w_baud_n  = '0;
            w_line_n  = 1'b1;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Summary  : Self-checking bench for uart_tx_fifo. Five configurations run in
//            parallel against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

   localparam int NCFG   = 5;
   localparam int NCYC   = 2500;
   localparam int RST_AT = 700;

   logic clk;
   int   n_checks = 0;
   int   n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Configuration table
   function automatic int cfg_cpb(int i);
      case (i)
         0, 1, 2: return 4;
         3:       return 3;
         default: return 5;
      endcase
   endfunction

   function automatic int cfg_db(int i);
      return (i == 4) ? 5 : 8;
   endfunction

   function automatic int cfg_par(int i);
      case (i)
         1:       return 1;
         2:       return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_stop(int i);
      return (i == 3) ? 2 : 1;
   endfunction

   function automatic int cfg_depth(int i);
      case (i)
         3:       return 4;
         4:       return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int cfg_first(int i);
      case (i)
         0:       return 32'hA5;
         1, 2:    return 32'h07;
         3:       return 32'h3C;
         default: return 32'h1F;
      endcase
   endfunction

   // Busy run length of the first directed traffic: one frame, except the
   // 5-bit config which queues a second word during the first frame.
   function automatic int cfg_run(int i);
      case (i)
         0:       return 40;
         1, 2:    return 44;
         3:       return 33;
         default: return 70;
      endcase
   endfunction

   // Peak queue depth during a 6-word burst into an idle transmitter.
   function automatic int cfg_maxcnt(int i);
      return (i == 3) ? 4 : 5;
   endfunction

   // Line level k cycles into the frame carrying 'word'.
   function automatic bit frame_bit(int word, int k, int cpb, int db, int par);
      int b;
      int ones;
      b    = k / cpb;
      ones = 0;
      for (int i = 0; i < db; i++) ones += (word >> i) & 1;
      if (b == 0) return 1'b0;
      if (b <= db) return bit'((word >> (b - 1)) & 1);
      if (par != 0 && b == db + 1) return (par == 1) ? bit'(ones % 2) : bit'(1 - ones % 2);
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      n_checks++;
      if (got !== 32'(exp)) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int CPB   = cfg_cpb(g);
      localparam int DB    = cfg_db(g);
      localparam int PAR   = cfg_par(g);
      localparam int SB    = cfg_stop(g);
      localparam int DEPTH = cfg_depth(g);
      localparam int CW    = $clog2(DEPTH) + 1;
      localparam int FLEN  = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * CPB;

      logic          rst_i;
      logic          busy_o;
      logic [CW-1:0] cnt_o;
      logic          line_o;

      uart_tx_fifo_if #(.DATA_BITS(DB)) ifc ();

      uart_tx_fifo #(
         .CLKS_PER_BIT (CPB),
         .DATA_BITS    (DB),
         .PARITY       (PAR),
         .STOP_BITS    (SB),
         .FIFO_DEPTH   (DEPTH)
      ) dut (
         .clk        (clk),
         .reset      (rst_i),
         .tx         (ifc.slave),
         .tx_busy    (busy_o),
         .fifo_count (cnt_o),
         .RsTx       (line_o)
      );

      initial begin : p_run
         int    src[$];
         int    fifo_m[$];
         int    cur_word;
         int    remaining;
         int    run_len;
         int    first_acc;
         int    first_low;
         int    max_cnt;
         bit    acc;
         bit    pop;
         bit    run_done;
         bit    exp_line;
         bit    rnd;
         bit    en;
         string pfx;

         pfx       = $sformatf("cfg%0d", g);
         cur_word  = 0;
         remaining = 0;
         run_len   = 0;
         run_done  = 1'b0;
         first_acc = -1;
         first_low = -1;
         max_cnt   = 0;
         rst_i        = 1'b1;
         ifc.tx_valid = 1'b0;
         ifc.tx_data  = '0;

         for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            // Reference: FIFO as a queue, a frame as a fixed-length list of
            // cycles; a new frame may start when idle or on the last cycle.
            acc = 1'b0;
            pop = 1'b0;
            if (rst_i) begin
               fifo_m.delete();
               remaining = 0;
            end else begin
               acc = ifc.tx_valid && (fifo_m.size() < DEPTH);
               pop = (remaining <= 1) && (fifo_m.size() > 0);
               if (pop) begin
                  cur_word  = fifo_m.pop_front();
                  remaining = FLEN;
               end else if (remaining > 0) begin
                  remaining--;
               end
               if (acc) begin
                  fifo_m.push_back(int'(ifc.tx_data));
                  src.delete(0);
               end
            end

            #1;
            exp_line = (remaining > 0) ? frame_bit(cur_word, FLEN - remaining, CPB, DB, PAR) : 1'b1;
            check({pfx, "_line"},  32'(line_o),       int'(exp_line));
            check({pfx, "_busy"},  32'(busy_o),       (remaining > 0) ? 1 : 0);
            check({pfx, "_count"}, 32'(cnt_o),        fifo_m.size());
            check({pfx, "_ready"}, 32'(ifc.tx_ready), (fifo_m.size() < DEPTH) ? 1 : 0);

            if (acc && first_acc < 0) first_acc = cyc;
            if (first_acc >= 0 && first_low < 0 && line_o === 1'b0) begin
               first_low = cyc;
               check({pfx, "_start_lat"}, 32'(cyc - first_acc), 1);
            end
            if (!run_done) begin
               if (busy_o === 1'b1) begin
                  run_len++;
               end else if (run_len > 0) begin
                  run_done = 1'b1;
                  check({pfx, "_run_len"}, 32'(run_len), cfg_run(g));
               end
            end
            if (cyc >= 100 && cyc < 200 && int'(cnt_o) > max_cnt) max_cnt = int'(cnt_o);
            if (cyc == 200) begin
               check({pfx, "_run_seen"}, 32'(run_done), 1);
               check({pfx, "_max_count"}, 32'(max_cnt), cfg_maxcnt(g));
            end

            // Stimulus for the next edge
            rst_i = (cyc < 2) || (cyc >= RST_AT && cyc < RST_AT + 3);
            if (cyc == 4) src.push_back(cfg_first(g));
            if (g == 4 && cyc == 10) src.push_back(32'h0A);
            if (cyc == 100) begin
               for (int k = 0; k < 6; k++) src.push_back(int'($urandom_range(0, (1 << DB) - 1)));
            end
            rnd = (cyc >= 200 && cyc < 1200);
            if (rnd && src.size() < 2 && $urandom_range(0, 7) == 0)
               src.push_back(int'($urandom_range(0, (1 << DB) - 1)));
            en = !rnd || ($urandom_range(0, 3) != 0);
            ifc.tx_valid = en && (src.size() > 0);
            ifc.tx_data  = ifc.tx_valid ? DB'(src[0]) : DB'($urandom);
         end
      end
   end

   initial begin : p_main
      repeat (NCYC + 3) @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
